adder_tree_pipe: RTL
====================

// Module: adder_tree_pipe
// PURPOSE
//  - Parametrised, fully pipelined N-input adder tree with valid tracking and a global clock enable.
//  - Generalises the fixed 32x33-bit tree: any N_INPUTS (non-power-of-2 inputs are zero-padded) and signed/unsigned mode.
//  - Sits in the DSP reduction datapath. Feeds the post-synth/post-route co-sim benches as golden + DUT.
// PARAMETERS
//  N_INPUTS   32   number of operands (>=2)
//  IN_WIDTH   33   width of each operand
//  SIGNED     0    0: operands/result unsigned, 1: two's complement (sign-extend per level)
//  LEVELS     $clog2(N_INPUTS)   derived, do not override
//  OUT_WIDTH  IN_WIDTH+LEVELS    derived result width (default 38)
//  ACC_EXTRA  8    extra accumulator headroom bits (used only with ADDER_TREE_ACC_EN)
// PORTS
//  clock         in   1                    rising-edge clock
//  reset_n       in   1                    synchronous, active-low reset
//  clock_ena     in   1                    1: pipeline advances; 0: every register holds
//  data          in   N_INPUTS*IN_WIDTH    operand i = data[i*IN_WIDTH +: IN_WIDTH]
//  data_valid    in   1                    operands qualified this cycle
//  result        out  OUT_WIDTH            sum of all operands
//  result_valid  out  1                    result qualified
//  acc_clear     in   1                    (ADDER_TREE_ACC_EN only) restart accumulation
//  acc_out       out  OUT_WIDTH+ACC_EXTRA  (ADDER_TREE_ACC_EN only) running sum
//  acc_valid     out  1                    (ADDER_TREE_ACC_EN only) acc_out updated last cycle
// BEHAVIOUR
//  - Reset (reset_n=0 at clock edge): all stage registers, result, result_valid, acc_out, acc_valid -> 0. Takes priority over clock_ena.
//  - Level k (1..LEVELS) pairs outputs of level k-1; width grows by 1 bit per level. Pad operands are 0.
//  - An odd operand at any level passes through extended (SIGNED: sign-ext, else zero-ext), still registered.
//  - One register per level: latency = LEVELS enabled cycles from data/data_valid to result/result_valid (5 at default).
//  - clock_ena=0: data and valid registers all freeze; outputs hold. No bubbles are inserted or dropped.
//  - data_valid=0: data still propagates (no gating), result_valid=0 for that slot. Result is don't-care but deterministic.
//  - Exact arithmetic: OUT_WIDTH is sufficient, so no overflow/wrap at any level in either mode.
//  - Throughput: one new operand set per enabled cycle; no backpressure beyond clock_ena.
//  - Reset mid-operation: all in-flight sums are discarded; result_valid stays 0 until LEVELS enabled cycles after the next data_valid.
// CONFIGURATION
//  - Macro ADDER_TREE_ACC_EN defined: adds an accumulator stage after the tree (+1 cycle for acc_out).
//    On enabled cycle with result_valid: acc_out <= (acc_clear ? 0 : acc_out) + ext(result); acc_valid <= 1.
//    acc_clear without result_valid: acc_out <= 0, acc_valid <= 0. Accumulation wraps modulo 2^(OUT_WIDTH+ACC_EXTRA).
//    acc_clear is sampled only when clock_ena=1.
//  - Macro not defined: acc_clear, acc_out and acc_valid ports do not exist. result/result_valid timing is identical in both builds.
// STRUCTURE
//  - Package adder_tree_pkg:
//    - function level_width(IN_WIDTH, k) = IN_WIDTH + k
//    - function level_count(N, k) = ceil(N / 2^k)
//    - localparam DEFAULT_ACC_EXTRA = 8
//  - Sub-module adder_tree_level: one registered level.
//    - Parameters: COUNT_IN, W_IN, SIGNED.
//    - Ports: clock, reset_n, clock_ena, in bus, valid in, out bus, valid out.
//    - Instantiated LEVELS times in a generate loop.
//  - Top: padding, generate chain, optional accumulator under `ifdef ADDER_TREE_ACC_EN.
// TESTING
//  - Default params, all operands 1, data_valid=1 -> result=32 with result_valid after exactly 5 enabled cycles.
//  - All operands 2^33-1, unsigned -> result = 32*(2^33-1) = 274877906912 (no truncation in 38 bits).
//  - SIGNED=1, N_INPUTS=5, IN_WIDTH=8, operands {-128,-128,-128,-128,127} -> result=-385 (11-bit), latency 3.
//  - Stream 100 random vectors, clock_ena toggled randomly -> every valid result matches the reference model. Order kept, count equal.
//  - reset_n=0 for 1 cycle with 3 sums in flight -> result_valid=0 and result=0 next cycle, no stale result emerges.
//  - ADDER_TREE_ACC_EN: results 10,20,30 with acc_clear on first -> acc_out 10,30,60. Then acc_clear with result 5 -> acc_out=5.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Package: adder_tree_pkg
// Shared sizing helpers for the pipelined adder tree.
//   level_width(w, k) : operand width after k adder levels (one bit of growth per level)
//   level_count(n, k) : operands left after k pairwise levels, ceil(n / 2^k)
//   DEFAULT_ACC_EXTRA : default accumulator headroom bits
package adder_tree_pkg;

    localparam int DEFAULT_ACC_EXTRA = 8;

    function automatic int level_width(input int w, input int k);
        return w + k;
    endfunction

    function automatic int level_count(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// Module: adder_tree_level
// One registered level of the adder tree. Adjacent operands are paired and
// summed one bit wider. If COUNT_IN is odd, the last operand has no partner.
// It is added to a zero pad, so it passes through extended and still registered.
// Ports:
//   clock, reset_n, clock_ena : rising-edge clock, sync active-low reset, advance enable
//   i_data / i_valid          : COUNT_IN operands of W_IN bits, slot qualifier
//   o_data / o_valid          : ceil(COUNT_IN/2) sums of W_IN+1 bits, slot qualifier
module adder_tree_level import adder_tree_pkg::*; #(
    parameter int COUNT_IN = 2,
    parameter int W_IN     = 8,
    parameter int SIGNED   = 0,
    localparam int COUNT_OUT = level_count(COUNT_IN, 1),
    localparam int W_OUT     = level_width(W_IN, 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clock_ena,
    input  logic [COUNT_IN*W_IN-1:0]   i_data,
    input  logic                       i_valid,
    output logic [COUNT_OUT*W_OUT-1:0] o_data,
    output logic                       o_valid
);

    function automatic logic [W_OUT-1:0] ext(input logic [W_IN-1:0] x);
        return (SIGNED != 0) ? {x[W_IN-1], x} : {1'b0, x};
    endfunction

    logic [COUNT_OUT*W_OUT-1:0] w_sum;
    logic [COUNT_OUT*W_OUT-1:0] r_data;
    logic                       r_valid;

    for (genvar j = 0; j < COUNT_OUT; j++) begin : g_pair
        logic [W_OUT-1:0] w_a;
        logic [W_OUT-1:0] w_b;
        assign w_a = ext(i_data[2*j*W_IN +: W_IN]);
        if (2*j + 1 < COUNT_IN) begin : g_partner
            assign w_b = ext(i_data[(2*j+1)*W_IN +: W_IN]);
        end else begin : g_pad
            assign w_b = '0;
        end
        assign w_sum[j*W_OUT +: W_OUT] = w_a + w_b;
    end

    // Data flows regardless of valid; only the qualifier marks the slot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (clock_ena) begin
            r_data  <= w_sum;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/adder_tree_pipe.sv
// Module: adder_tree_pipe
// Fully pipelined N_INPUTS-operand adder tree with valid tracking and a global
// clock enable. The tree has one register per level, so latency is LEVELS
// enabled cycles. Arithmetic is exact in OUT_WIDTH bits, signed or unsigned.
// Optional feature macro: ADDER_TREE_ACC_EN adds a wrapping accumulator after
// the tree. It adds one cycle for acc_out and leaves result timing unchanged.
// Ports:
//   clock, reset_n, clock_ena : rising-edge clock, sync active-low reset, advance enable
//   data / data_valid         : operand i = data[i*IN_WIDTH +: IN_WIDTH], slot qualifier
//   result / result_valid     : sum of all operands, qualifier
//   acc_clear, acc_out, acc_valid : accumulator (ADDER_TREE_ACC_EN builds only)
module adder_tree_pipe import adder_tree_pkg::*; #(
    parameter int N_INPUTS  = 32,
    parameter int IN_WIDTH  = 33,
    parameter int SIGNED    = 0,
    parameter int ACC_EXTRA = DEFAULT_ACC_EXTRA,
    localparam int LEVELS    = $clog2(N_INPUTS),
    localparam int OUT_WIDTH = level_width(IN_WIDTH, LEVELS)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clock_ena,
    input  logic [N_INPUTS*IN_WIDTH-1:0] data,
    input  logic                         data_valid,
    output logic [OUT_WIDTH-1:0]         result,
    output logic                         result_valid
`ifdef ADDER_TREE_ACC_EN
    ,
    input  logic                         acc_clear,
    output logic [OUT_WIDTH+ACC_EXTRA-1:0] acc_out,
    output logic                         acc_valid
`endif
);

    if (N_INPUTS < 2 || ACC_EXTRA < 0) begin : g_bad_params
        $error("adder_tree_pipe: N_INPUTS must be >= 2 and ACC_EXTRA >= 0");
    end

    // Level k consumes level k-1. If the operand count is odd, the spare
    // operand is paired with zero.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int CIN  = level_count(N_INPUTS, k-1);
        localparam int WIN  = level_width(IN_WIDTH, k-1);
        localparam int COUT = level_count(N_INPUTS, k);

        logic [CIN*WIN-1:0]      w_in;
        logic                    w_vin;
        logic [COUT*(WIN+1)-1:0] w_out;
        logic                    w_vout;

        if (k == 1) begin : g_src
            assign w_in  = data;
            assign w_vin = data_valid;
        end else begin : g_src
            assign w_in  = g_lvl[k-1].w_out;
            assign w_vin = g_lvl[k-1].w_vout;
        end

        adder_tree_level #(
            .COUNT_IN (CIN),
            .W_IN     (WIN),
            .SIGNED   (SIGNED)
        ) u_level (
            .clock     (clock),
            .reset_n   (reset_n),
            .clock_ena (clock_ena),
            .i_data    (w_in),
            .i_valid   (w_vin),
            .o_data    (w_out),
            .o_valid   (w_vout)
        );
    end

    assign result       = g_lvl[LEVELS].w_out;
    assign result_valid = g_lvl[LEVELS].w_vout;

`ifdef ADDER_TREE_ACC_EN
    localparam int ACC_WIDTH = OUT_WIDTH + ACC_EXTRA;

    logic [ACC_WIDTH-1:0] w_res_ext;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_acc_valid;

    assign w_res_ext = (SIGNED != 0) ? {{ACC_EXTRA{result[OUT_WIDTH-1]}}, result}
                                     : {{ACC_EXTRA{1'b0}}, result};

    // acc_clear together with a valid result restarts the sum from this
    // result. Without a valid result it only zeroes the accumulator.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
        end else if (clock_ena) begin
            if (result_valid) begin
                r_acc       <= (acc_clear ? '0 : r_acc) + w_res_ext;
                r_acc_valid <= 1'b1;
            end else begin
                if (acc_clear) begin
                    r_acc <= '0;
                end
                r_acc_valid <= 1'b0;
            end
        end
    end

    assign acc_out   = r_acc;
    assign acc_valid = r_acc_valid;
`endif

endmodule
